// File: rtl/stage_par_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage_par_pkg
// Description : Shared types and constants for the stage_par layer stage.
//               State encoding, the per-vector configuration record and
//               the saturation limits for the default 16-bit data width.
// Revision    : 1.0 - initial release
// ============================================================================
package stage_par_pkg;

    // Control FSM encoding
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LOAD    = 2'd1;
    localparam logic [1:0] c_ST_COMPUTE = 2'd2;
    localparam logic [1:0] c_ST_OUT     = 2'd3;

    // Configuration captured when a row computation begins
    typedef struct packed {
        logic relu_en;
    } stage_par_cfg_t;

    // Output saturation limits at the default data width. The datapath
    // builds the same limits generically from its DW parameter.
    localparam int c_SAT_DW  = 16;
    localparam int c_SAT_MAX = (1 << (c_SAT_DW - 1)) - 1;
    localparam int c_SAT_MIN = -(1 << (c_SAT_DW - 1));

endpackage : stage_par_pkg
`default_nettype wire

// File: rtl/stage_par_mac.sv
`default_nettype none
// ============================================================================
// Module      : stage_par_mac
// Description : Multiply-accumulate datapath. LANES signed DWxDW products
//               are summed and added into an AW-bit accumulator.
//   i_clr   : load accumulator with i_init (takes priority over i_en)
//   i_en    : add the sum of this cycle's LANES products
//   i_init  : accumulator initial value
//   i_taps  : LANES packed tap values
//   i_data  : LANES packed data values
//   o_acc_next : accumulator value that will be stored at this clock edge
// Revision    : 1.0 - initial release
// ============================================================================
module stage_par_mac
    import stage_par_pkg::*;
#(
    parameter int DW    = 16,
    parameter int LANES = 2,
    parameter int AW    = 36
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [AW-1:0]         i_init,
    input  logic [LANES*DW-1:0]   i_taps,
    input  logic [LANES*DW-1:0]   i_data,
    output logic [AW-1:0]         o_acc_next
);

    logic signed [2*DW-1:0] w_prod [LANES];
    logic        [AW-1:0]   w_sum;
    logic        [AW-1:0]   r_acc;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_prod[j] = $signed(i_taps[j*DW +: DW]) * $signed(i_data[j*DW +: DW]);
    end

    // Sign-extend each product to the accumulator width before summing
    always_comb begin
        w_sum = '0;
        for (int j = 0; j < LANES; j++) begin
            w_sum = w_sum + {{(AW-2*DW){w_prod[j][2*DW-1]}}, w_prod[j]};
        end
    end

    always_comb begin
        o_acc_next = r_acc;
        if (i_clr) begin
            o_acc_next = i_init;
        end else if (i_en) begin
            o_acc_next = r_acc + w_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_acc_next;
        end
    end

endmodule : stage_par_mac
`default_nettype wire

// File: rtl/stage_par.sv
`default_nettype none
// ============================================================================
// Module      : stage_par
// Description : Fixed-point layer stage. Buffers one NUM_IN-element input
//               vector and produces NUM_OUT outputs
//               y[o] = act(bias[o] + sum_i tap[o][i]*x[i]) using LANES
//               multipliers per cycle, streamed out with valid/ready.
//   clk, reset             : clock, synchronous active-high reset
//   relu_en                : clamp negative results to zero
//   tap_in/_vld/_fst/_rdy  : tap word write stream (LANES taps per word)
//   bias_in/_vld/_fst/_rdy : bias write stream
//   data_in/_vld/_fst/_rdy : input vector element stream
//   data_out/_vld/_fst/_rdy: result stream, fst marks y[0]
// Revision    : 1.0 - initial release
// ============================================================================
module stage_par
    import stage_par_pkg::*;
#(
    parameter int DW      = 16,
    parameter int FRAC    = 8,
    parameter int NUM_IN  = 8,
    parameter int NUM_OUT = 4,
    parameter int LANES   = 2,
    parameter int AW      = 2*DW + $clog2(NUM_IN) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  relu_en,
    input  logic [LANES*DW-1:0]   tap_in,
    input  logic                  tap_in_vld,
    input  logic                  tap_in_fst,
    output logic                  tap_in_rdy,
    input  logic [DW-1:0]         bias_in,
    input  logic                  bias_in_vld,
    input  logic                  bias_in_fst,
    output logic                  bias_in_rdy,
    input  logic [DW-1:0]         data_in,
    input  logic                  data_in_vld,
    input  logic                  data_in_fst,
    output logic                  data_in_rdy,
    output logic [DW-1:0]         data_out,
    output logic                  data_out_vld,
    output logic                  data_out_fst,
    input  logic                  data_out_rdy
);

    localparam int c_K      = NUM_IN / LANES;
    localparam int c_TDEPTH = NUM_OUT * c_K;
    localparam int c_TAW    = (c_TDEPTH > 1) ? $clog2(c_TDEPTH) : 1;
    localparam int c_BAW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int c_XIW    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int c_CW     = $clog2(NUM_IN + 1);
    localparam int c_KW     = $clog2(c_K + 1);

    localparam logic signed [AW-1:0] c_SAT_HI = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] c_SAT_LO = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [1:0]             r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_KW-1:0]        r_k;
    logic [c_BAW-1:0]       r_o;
    logic [c_TAW-1:0]       r_tap_addr;
    logic [c_BAW-1:0]       r_bias_addr;
    logic [DW-1:0]          r_data_out;
    stage_par_cfg_t         r_cfg;

    logic [LANES*DW-1:0]    r_tap_mem [c_TDEPTH];
    logic [LANES*DW-1:0]    r_tap_rd;
    logic [DW-1:0]          r_bias [NUM_OUT];
    logic [DW-1:0]          r_x [NUM_IN];

    logic                   w_tap_we;
    logic                   w_bias_we;
    logic                   w_data_hs;
    logic [c_TAW-1:0]       w_tap_wa;
    logic [c_BAW-1:0]       w_bias_wa;
    logic [c_CW-1:0]        w_cnt_next;
    logic [c_TAW-1:0]       w_rd_addr;
    logic [LANES*DW-1:0]    w_lane_x;
    logic [DW-1:0]          w_bias_cur;
    logic [AW-1:0]          w_init;
    logic                   w_mac_clr;
    logic                   w_mac_en;
    logic [AW-1:0]          w_acc_next;
    logic signed [AW-1:0]   w_shift;
    logic [DW-1:0]          w_res;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign tap_in_rdy  = (r_state == c_ST_IDLE) && !reset;
    assign bias_in_rdy = (r_state == c_ST_IDLE) && !reset;
    assign data_in_rdy = ((r_state == c_ST_IDLE) || (r_state == c_ST_LOAD)) && !reset;

    assign w_tap_we  = tap_in_vld  && tap_in_rdy;
    assign w_bias_we = bias_in_vld && bias_in_rdy;
    assign w_data_hs = data_in_vld && data_in_rdy;

    // A first-marked beat always lands at address 0
    assign w_tap_wa  = tap_in_fst  ? '0 : r_tap_addr;
    assign w_bias_wa = bias_in_fst ? '0 : r_bias_addr;

    assign w_cnt_next = data_in_fst ? c_CW'(1) : r_cnt + c_CW'(1);

    // ------------------------------------------------------------------
    // Tap memory: synchronous write, 1-cycle synchronous read
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_addr = c_TAW'(32'(r_o) * c_K);
        if (r_k < c_KW'(c_K)) begin
            w_rd_addr = c_TAW'(32'(r_o) * c_K + 32'(r_k));
        end
    end

    always_ff @(posedge clk) begin
        if (w_tap_we) begin
            r_tap_mem[w_tap_wa] <= tap_in;
        end
        r_tap_rd <= r_tap_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (w_bias_we) begin
            r_bias[w_bias_wa] <= bias_in;
        end
    end

    // Input vector buffer; a first-marked beat restarts at x[0]
    always_ff @(posedge clk) begin
        if (w_data_hs && data_in_fst) begin
            r_x[0] <= data_in;
        end else if (w_data_hs && (r_state == c_ST_LOAD)) begin
            r_x[c_XIW'(r_cnt)] <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: accumulate cycle k (1..K) consumes tap word k-1, which
    // was read in the previous cycle, against x[(k-1)*LANES + j].
    // ------------------------------------------------------------------
    always_comb begin
        w_lane_x = '0;
        for (int j = 0; j < LANES; j++) begin
            if (r_k != '0) begin
                w_lane_x[j*DW +: DW] = r_x[c_XIW'((int'(r_k) - 1) * LANES + j)];
            end
        end
    end

    assign w_bias_cur = r_bias[r_o];
    assign w_init     = {{(AW-DW){w_bias_cur[DW-1]}}, w_bias_cur} << FRAC;
    assign w_mac_clr  = (r_state == c_ST_COMPUTE) && (r_k == '0);
    assign w_mac_en   = (r_state == c_ST_COMPUTE) && (r_k != '0);

    stage_par_mac #(
        .DW    (DW),
        .LANES (LANES),
        .AW    (AW)
    ) u_mac (
        .clk        (clk),
        .rst        (reset),
        .i_clr      (w_mac_clr),
        .i_en       (w_mac_en),
        .i_init     (w_init),
        .i_taps     (r_tap_rd),
        .i_data     (w_lane_x),
        .o_acc_next (w_acc_next)
    );

    // The final accumulate and the output register share the same edge,
    // so the result is formed from the accumulator's next value.
    assign w_shift = $signed(w_acc_next) >>> FRAC;

    always_comb begin
        if (w_shift > c_SAT_HI) begin
            w_res = c_SAT_HI[DW-1:0];
        end else if (w_shift < c_SAT_LO) begin
            w_res = c_SAT_LO[DW-1:0];
        end else begin
            w_res = w_shift[DW-1:0];
        end
        if (r_cfg.relu_en && w_res[DW-1]) begin
            w_res = '0;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_k         <= '0;
            r_o         <= '0;
            r_tap_addr  <= '0;
            r_bias_addr <= '0;
            r_data_out  <= '0;
            r_cfg       <= '0;
        end else begin
            if (w_tap_we) begin
                r_tap_addr <= (w_tap_wa == c_TAW'(c_TDEPTH - 1)) ? '0 : w_tap_wa + c_TAW'(1);
            end
            if (w_bias_we) begin
                r_bias_addr <= (w_bias_wa == c_BAW'(NUM_OUT - 1)) ? '0 : w_bias_wa + c_BAW'(1);
            end

            case (r_state)
                c_ST_IDLE: begin
                    // Non-first beats in IDLE are accepted and dropped
                    if (w_data_hs && data_in_fst) begin
                        r_cnt <= c_CW'(1);
                        if (NUM_IN == 1) begin
                            r_state <= c_ST_COMPUTE;
                            r_k     <= '0;
                            r_o     <= '0;
                        end else begin
                            r_state <= c_ST_LOAD;
                        end
                    end
                end
                c_ST_LOAD: begin
                    if (w_data_hs) begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == c_CW'(NUM_IN)) begin
                            r_state <= c_ST_COMPUTE;
                            r_k     <= '0;
                            r_o     <= '0;
                        end
                    end
                end
                c_ST_COMPUTE: begin
                    if (r_k == '0) begin
                        r_cfg.relu_en <= relu_en;
                    end
                    if (r_k == c_KW'(c_K)) begin
                        r_data_out <= w_res;
                        r_state    <= c_ST_OUT;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                c_ST_OUT: begin
                    if (data_out_rdy) begin
                        if (r_o == c_BAW'(NUM_OUT - 1)) begin
                            r_state <= c_ST_IDLE;
                            r_o     <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= c_ST_COMPUTE;
                            r_o     <= r_o + c_BAW'(1);
                            r_k     <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet during the reset cycle itself
    assign data_out_vld = (r_state == c_ST_OUT) && !reset;
    assign data_out_fst = data_out_vld && (r_o == '0);
    assign data_out     = reset ? '0 : r_data_out;

endmodule : stage_par
`default_nettype wire
